// File: rtl/hv_pkg.sv
// Shared constants and types for the hypervector bundler.
// Optional feature macro: HV_TIE_LFSR_EN (LFSR tie-break instead of d[0]).
package hv_pkg;

   localparam int DEF_DIM     = 1024;
   localparam int DEF_CHUNK   = 32;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_NCHUNK  = DEF_DIM / DEF_CHUNK;
   localparam int DEF_MAX_VEC = (1 << DEF_CNT_W) - 1;

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form: taps at bits 0,2,3,5
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   typedef enum logic {
      ACCUM = 1'b0,
      OUT   = 1'b1
   } state_t;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic fb;
      fb = ^(s & LFSR_TAPS);
      return {fb, s[15:1]};
   endfunction

endpackage

// File: rtl/hv_majority_chunk.sv
// Combinational majority quantizer for one chunk of per-dimension counters.
// Optional feature macro: HV_TIE_LFSR_EN (only affects where tie_vec comes from).
module hv_majority_chunk
   import hv_pkg::*;
#(
   parameter int CHUNK = DEF_CHUNK,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic [CHUNK*CNT_W-1:0] cnt_flat,
   input  logic [CNT_W-1:0]       n_vec,
   input  logic [CHUNK-1:0]       tie_vec,
   output logic [CHUNK-1:0]       maj
);

   // Compare twice the ones-count against the vector count, one bit wider to avoid overflow
   always_comb begin
      logic [CNT_W:0] twice_cnt;
      logic [CNT_W:0] ref_cnt;
      maj       = '0;
      twice_cnt = '0;
      ref_cnt   = {1'b0, n_vec};
      for (int j = 0; j < CHUNK; j++) begin
         twice_cnt = {cnt_flat[j*CNT_W +: CNT_W], 1'b0};
         if (twice_cnt > ref_cnt) begin
            maj[j] = 1'b1;
         end else if (twice_cnt < ref_cnt) begin
            maj[j] = 1'b0;
         end else begin
            maj[j] = tie_vec[j];
         end
      end
   end

endmodule

// File: rtl/hv_bundler.sv
// Hypervector bundler: accumulates per-dimension ones-counts over a stream of
// bound hypervectors, then streams out the majority-quantized query.
// Optional feature macro: HV_TIE_LFSR_EN (ties broken by a 16-bit LFSR).
module hv_bundler
   import hv_pkg::*;
#(
   parameter int DIM   = DEF_DIM,
   parameter int CHUNK = DEF_CHUNK,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CHUNK-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CHUNK-1:0] out_data,
   output logic             out_last,
   output logic             ovf_err,
   output logic             proto_err
);

   localparam int NCHUNK = DIM / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] MAX_VEC  = {CNT_W{1'b1}};
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] n_vec_q, n_vec_d;
   logic             ovf_q, ovf_d;
   logic             proto_q, proto_d;

   logic [CNT_W-1:0] cnt_q     [NCHUNK][CHUNK];
   logic [CNT_W-1:0] cnt_row_d [CHUNK];
   logic             cnt_we;

   logic                   at_last;
   logic                   saturated;
   logic [CHUNK*CNT_W-1:0] cnt_flat;
   logic [CHUNK-1:0]       tie_vec;
   logic [CHUNK-1:0]       maj;

   assign at_last   = (idx_q == LAST_IDX);
   assign saturated = (n_vec_q == MAX_VEC);

   // Next-state, counter-row update and handshake outputs for the ACCUM/OUT FSM
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      n_vec_d   = n_vec_q;
      ovf_d     = ovf_q;
      proto_d   = proto_q;
      cnt_we    = 1'b0;
      cnt_row_d = cnt_q[idx_q];
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state_q)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (saturated) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_we = 1'b1;
                  for (int j = 0; j < CHUNK; j++) begin
                     cnt_row_d[j] = cnt_q[idx_q][j] + CNT_W'(in_data[j]);
                  end
               end
               if (in_last && !at_last) begin
                  proto_d = 1'b1;
               end
               if (at_last) begin
                  idx_d = '0;
                  if (!saturated) begin
                     n_vec_d = n_vec_q + 1'b1;
                  end
                  if (in_last) begin
                     state_d = OUT;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         OUT: begin
            out_valid = 1'b1;
            out_last  = at_last;
            if (out_ready) begin
               cnt_we = 1'b1;
               for (int j = 0; j < CHUNK; j++) begin
                  cnt_row_d[j] = '0;
               end
               if (at_last) begin
                  state_d = ACCUM;
                  idx_d   = '0;
                  n_vec_d = '0;
                  ovf_d   = 1'b0;
                  proto_d = 1'b0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         idx_q   <= '0;
         n_vec_q <= '0;
         ovf_q   <= 1'b0;
         proto_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         n_vec_q <= n_vec_d;
         ovf_q   <= ovf_d;
         proto_q <= proto_d;
      end
   end

   // Per-dimension counters; only the row of the current chunk is written each cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCHUNK; k++) begin
            for (int j = 0; j < CHUNK; j++) begin
               cnt_q[k][j] <= '0;
            end
         end
      end else if (cnt_we) begin
         for (int j = 0; j < CHUNK; j++) begin
            cnt_q[idx_q][j] <= cnt_row_d[j];
         end
      end
   end

   // Flatten the current chunk's counters for the quantizer
   always_comb begin
      cnt_flat = '0;
      for (int j = 0; j < CHUNK; j++) begin
         cnt_flat[j*CNT_W +: CNT_W] = cnt_q[idx_q][j];
      end
   end

`ifdef HV_TIE_LFSR_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Walk the LFSR one step per dimension of the chunk; commit the walk on each output beat
   always_comb begin
      logic [15:0] walk;
      walk    = lfsr_q;
      tie_vec = '0;
      for (int j = 0; j < CHUNK; j++) begin
         tie_vec[j] = walk[0];
         walk       = lfsr_step(walk);
      end
      lfsr_d = (out_valid && out_ready) ? walk : lfsr_q;
   end

   // LFSR state register, restarted from the seed on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   // Deterministic tie-break: the parity of the absolute dimension index
   always_comb begin
      int dim_idx;
      tie_vec = '0;
      dim_idx = 0;
      for (int j = 0; j < CHUNK; j++) begin
         dim_idx    = int'(idx_q) * CHUNK + j;
         tie_vec[j] = dim_idx[0];
      end
   end
`endif

   hv_majority_chunk #(
      .CHUNK (CHUNK),
      .CNT_W (CNT_W)
   ) u_majority (
      .cnt_flat (cnt_flat),
      .n_vec    (n_vec_q),
      .tie_vec  (tie_vec),
      .maj      (maj)
   );

   assign out_data  = out_valid ? maj : '0;
   assign ovf_err   = ovf_q;
   assign proto_err = proto_q;

endmodule

// File: tb/tb_hv_bundler.sv
// Directed self-checking bench for hv_bundler (default DIM=1024, CHUNK=32, CNT_W=8).
// Tie expectations follow HV_TIE_LFSR_EN when that macro is defined.
module tb_hv_bundler;

   localparam int CHUNK  = 32;
   localparam int NCHUNK = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [CHUNK-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [CHUNK-1:0] out_data;
   logic             out_last;
   logic             ovf_err;
   logic             proto_err;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] tbLfsr = 16'hACE1;

   hv_bundler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .ovf_err   (ovf_err),
      .proto_err (proto_err)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // One input beat; waits (bounded) for in_ready, handshake at the next rising edge
   task automatic applyStimulus(input logic [31:0] data, input logic last);
      int waitCnt;
      waitCnt  = 0;
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      while (!in_ready && waitCnt < 100) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic sendVector(input logic [31:0] data, input logic isLast);
      for (int b = 0; b < NCHUNK; b++) begin
         applyStimulus(data, isLast && (b == NCHUNK - 1));
      end
   endtask

   // Reference tie bits: bit 0 of successive LFSR states, or the dimension parity
   function automatic logic [31:0] tieExpect();
      logic [31:0] e;
      e = 32'hAAAAAAAA;
`ifdef HV_TIE_LFSR_EN
      for (int j = 0; j < CHUNK; j++) begin
         e[j]   = tbLfsr[0];
         tbLfsr = {tbLfsr[0] ^ tbLfsr[2] ^ tbLfsr[3] ^ tbLfsr[5], tbLfsr[15:1]};
      end
`endif
      return e;
   endfunction

   // Drain a full query, optionally stalling out_ready for 5 cycles at one beat
   task automatic collectQuery(input logic [31:0] expData, input bit tieMode, input int stallAt);
      logic [31:0] exp;
      int          waitCnt;
      for (int b = 0; b < NCHUNK; b++) begin
         waitCnt = 0;
         while (!out_valid && waitCnt < 100) begin
            @(posedge clk); #1;
            waitCnt++;
         end
         if (!out_valid) checkOutput("out_valid_timeout", 32'd0, 32'd1);
         exp = tieMode ? tieExpect() : expData;
         checkOutput($sformatf("out_data[%0d]", b), out_data, exp);
         checkOutput($sformatf("out_last[%0d]", b), {31'd0, out_last}, {31'd0, b == NCHUNK - 1});
         if (b == stallAt) begin
            for (int s = 0; s < 5; s++) begin
               @(posedge clk); #1;
               checkOutput("stall_data", out_data, exp);
               checkOutput("stall_last", {31'd0, out_last}, 32'd0);
               checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
               checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   // Asynchronous reset pulse with the outputs checked while reset is held
   task automatic doReset();
      rst_n = 1'b0;
      #2;
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);
      checkOutput("rst_out_data", out_data, 32'd0);
      checkOutput("rst_ovf_err", {31'd0, ovf_err}, 32'd0);
      checkOutput("rst_proto_err", {31'd0, proto_err}, 32'd0);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      tbLfsr = 16'hACE1;
      @(posedge clk); #1;
   endtask

   // Main directed sequence
   initial begin
      #1;
      doReset();

      // Single vector reproduces the input; check 1-cycle output latency
      for (int b = 0; b < NCHUNK; b++) begin
         applyStimulus(32'hA5A5A5A5, b == NCHUNK - 1);
         if (b == 0) checkOutput("accum_out_valid", {31'd0, out_valid}, 32'd0);
      end
      checkOutput("latency_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("latency_in_ready", {31'd0, in_ready}, 32'd0);
      collectQuery(32'hA5A5A5A5, 1'b0, -1);
      checkOutput("post_in_ready", {31'd0, in_ready}, 32'd1);

      // Three-vector majority with a mid-query stall
      sendVector(32'hFFFF0000, 1'b0);
      sendVector(32'hFF00FF00, 1'b0);
      sendVector(32'h00000000, 1'b1);
      collectQuery(32'hFF000000, 1'b0, 10);

      // Fresh all-zero bundle shows the counters were cleared
      sendVector(32'h00000000, 1'b1);
      collectQuery(32'h00000000, 1'b0, -1);

      // Every dimension ties; start from reset so the LFSR model is aligned
      doReset();
      sendVector(32'hFFFFFFFF, 1'b0);
      sendVector(32'h00000000, 1'b1);
      collectQuery(32'h0, 1'b1, -1);

      // Saturation: 255 vectors fill the counters, the 256th is discarded
      for (int v = 0; v < 255; v++) begin
         sendVector(32'hFFFFFFFF, 1'b0);
      end
      checkOutput("ovf_before", {31'd0, ovf_err}, 32'd0);
      applyStimulus(32'hFFFFFFFF, 1'b0);
      checkOutput("ovf_set", {31'd0, ovf_err}, 32'd1);
      for (int b = 1; b < NCHUNK; b++) begin
         applyStimulus(32'hFFFFFFFF, b == NCHUNK - 1);
      end
      checkOutput("ovf_in_out", {31'd0, ovf_err}, 32'd1);
      collectQuery(32'hFFFFFFFF, 1'b0, -1);
      checkOutput("ovf_cleared", {31'd0, ovf_err}, 32'd0);

      // Premature in_last flags a protocol error without leaving ACCUM
      for (int b = 0; b < 6; b++) begin
         applyStimulus(32'h0F0F0F0F, b == 5);
      end
      checkOutput("proto_set", {31'd0, proto_err}, 32'd1);
      checkOutput("proto_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("proto_in_ready", {31'd0, in_ready}, 32'd1);
      for (int b = 0; b < 3; b++) begin
         applyStimulus(32'hFFFFFFFF, 1'b0);
      end

      // Reset mid-bundle discards the partial accumulation
      doReset();
      sendVector(32'h3C96E187, 1'b1);
      collectQuery(32'h3C96E187, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
